line_reorder_buffer: RTL and testbench

- Parametrised, single-clock successor to the ROIC input reorder stage.
- Captures one ROIC line of LINE_LEN samples into one of two ping-pong RAM banks, using an interleaved write address.
- Streams completed lines out sequentially on a valid/ready interface with a last marker.
- Adds bypass mode, back-pressure, overflow/short-line detection and a deterministic test pattern; sits between the ROIC deserializer and the line formatter.

---
 rtl/line_reorder_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_line_reorder_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_reorder_buffer.sv
// Ping-pong line buffer: captures one ROIC line with an interleaved write
// address and streams it out in order through a 2-entry valid/ready stage.
module line_reorder_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int LINE_LEN   = 256,
  parameter int INTERLEAVE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_line_start,
  input  logic                  cfg_bypass,
  input  logic                  cfg_test_pattern,
  input  logic                  clr_status,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            full_banks,
  output logic                  wr_active,
  output logic                  err_short,
  output logic                  ovf_sticky
);

  localparam int AW = $clog2(LINE_LEN);
  localparam int IW = $clog2(INTERLEAVE);
  localparam logic [AW-1:0] KMAX = AW'(LINE_LEN - 1);

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_t;

  logic [DATA_WIDTH-1:0] mem [2*LINE_LEN];

  logic [1:0]            bank_full;
  logic [1:0]            set_mask;
  logic [1:0]            clr_mask;
  logic                  wr_bank;
  logic                  rd_bank;
  logic                  iss_bank;
  logic [AW-1:0]         k;
  logic [AW-1:0]         ra;
  logic                  lat_bypass;
  logic                  lat_tp;

  logic                  line_start;
  logic                  bank_free;
  logic                  start_ok;
  logic                  we;
  logic                  done;
  logic [AW-1:0]         kk;
  logic                  byp;
  logic                  tp;
  logic [AW-1:0]         wa;
  logic [DATA_WIDTH-1:0] wd;

  logic                  pop;
  logic                  rel;
  logic                  rd_go;
  logic                  rd_en;
  logic                  move;
  rd_state_t             rd_state;
  rd_state_t             rd_next;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  rq_v;
  logic                  rq_last;
  logic [DATA_WIDTH-1:0] sk_d;
  logic                  sk_v;
  logic                  sk_last;

  // ---------------- write side ----------------
  assign line_start = in_valid & in_line_start;
  assign pop        = out_valid & out_ready;
  assign rel        = pop & out_last;
  assign bank_free  = !bank_full[wr_bank] |
                      (rel & (rd_bank == wr_bank));
  assign start_ok   = line_start & (wr_active | bank_free);
  assign we         = start_ok |
                      (in_valid & wr_active & !line_start);
  assign done       = in_valid & wr_active & !line_start &
                      (k == KMAX);

  assign kk  = line_start ? '0 : k;
  assign byp = line_start ? cfg_bypass : lat_bypass;
  assign tp  = line_start ? cfg_test_pattern : lat_tp;
  // reorder address is k rotated right by log2(INTERLEAVE)
  assign wa  = byp ? kk : {kk[IW-1:0], kk[AW-1:IW]};
  assign wd  = tp ? DATA_WIDTH'(kk) : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_active  <= 1'b0;
      wr_bank    <= 1'b0;
      k          <= '0;
      lat_bypass <= 1'b0;
      lat_tp     <= 1'b0;
      err_short  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      err_short  <= line_start & wr_active;
      ovf_sticky <= (line_start & !wr_active & !bank_free) |
                    (ovf_sticky & !clr_status);
      if (start_ok) begin
        wr_active  <= 1'b1;
        k          <= AW'(1);
        lat_bypass <= cfg_bypass;
        lat_tp     <= cfg_test_pattern;
      end else if (done) begin
        wr_active <= 1'b0;
        k         <= '0;
        wr_bank   <= !wr_bank;
      end else if (we) begin
        k <= k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wa}] <= wd;
  end

  // ---------------- bank bookkeeping ----------------
  assign set_mask = {done & wr_bank, done & !wr_bank};
  assign clr_mask = {rel & rd_bank, rel & !rd_bank};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
      rd_bank   <= 1'b0;
    end else begin
      bank_full <= (bank_full & ~clr_mask) | set_mask;
      rd_bank   <= rd_bank ^ rel;
    end
  end

  assign full_banks = {1'b0, bank_full[0]} +
                      {1'b0, bank_full[1]};

  // ---------------- read issue FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (rd_en) rd_next = RD_RUN;
      RD_RUN:  if (rd_en && ra == KMAX) rd_next = RD_IDLE;
    endcase
  end

  // issue only when the output stage has room after this cycle's pop
  always_comb begin
    rd_go = 1'b0;
    unique case (rd_state)
      RD_IDLE: rd_go = bank_full[iss_bank];
      RD_RUN:  rd_go = 1'b1;
    endcase
    rd_en = rd_go & (!sk_v | pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra       <= '0;
      iss_bank <= 1'b0;
    end else if (rd_en) begin
      ra <= ra + 1'b1;
      if (ra == KMAX) iss_bank <= !iss_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[{iss_bank, ra}];
  end

  // ---------------- output stage ----------------
  // sk holds the older beat when both entries are occupied
  assign move = rd_en & rq_v & !(pop & !sk_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_v    <= 1'b0;
      rq_last <= 1'b0;
      sk_v    <= 1'b0;
      sk_last <= 1'b0;
      sk_d    <= '0;
    end else begin
      rq_v <= rd_en | (rq_v & !(pop & !sk_v));
      if (rd_en) rq_last <= (ra == KMAX);
      if (move) begin
        sk_v    <= 1'b1;
        sk_d    <= rdata;
        sk_last <= rq_last;
      end else if (pop & sk_v) begin
        sk_v <= 1'b0;
      end
    end
  end

  assign out_valid = sk_v | rq_v;
  assign out_data  = sk_v ? sk_d :
                     (rq_v ? rdata : '0);
  assign out_last  = sk_v ? sk_last : (rq_v & rq_last);

endmodule

// File: tb/tb_line_reorder_buffer.sv
// Randomised bench for line_reorder_buffer with a line-level
// reference model of bank occupancy, drops and output ordering.
module tb_line_reorder_buffer;

  localparam int DW  = 24;
  localparam int LL  = 256;
  localparam int IL  = 4;
  localparam int LPI = LL / IL;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_line_start;
  logic          cfg_bypass;
  logic          cfg_test_pattern;
  logic          clr_status;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    full_banks;
  logic          wr_active;
  logic          err_short;
  logic          ovf_sticky;

  line_reorder_buffer #(
    .DATA_WIDTH(DW),
    .LINE_LEN(LL),
    .INTERLEAVE(IL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_line_start(in_line_start),
    .cfg_bypass(cfg_bypass),
    .cfg_test_pattern(cfg_test_pattern),
    .clr_status(clr_status),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .full_banks(full_banks),
    .wr_active(wr_active),
    .err_short(err_short),
    .ovf_sticky(ovf_sticky)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] seen[$];
  logic [DW-1:0] m_line [LL];
  int            m_k;
  bit            m_active;
  bit            m_byp;
  bit            m_tp;
  int            m_full;
  bit            m_err;
  bit            m_ovf;
  int            cyc;
  int            done_cyc;
  int            rise_cyc;
  int            n_err;
  bit            p_valid;
  bit            p_ready;
  logic [DW-1:0] p_data;
  bit            p_last;
  int            ready_mode;

  task automatic chk(input string tag,
                     input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got_v, exp_v);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // reference model: one step per cycle, outputs compared first
  always @(negedge clk) begin
    bit rel;
    bit set_ovf;
    bit done;
    int idx;
    beat_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_k      = 0;
      m_active = 0;
      m_full   = 0;
      m_err    = 0;
      m_ovf    = 0;
      p_valid  = 0;
      p_ready  = 0;
    end else begin
      rel     = 0;
      set_ovf = 0;
      done    = 0;
      chk("full_banks", 32'(full_banks), 32'(m_full));
      chk("wr_active", 32'(wr_active), 32'(m_active));
      chk("err_short", 32'(err_short), 32'(m_err));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
      if (err_short) n_err++;
      if (p_valid && !p_ready) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(p_data));
        chk("stall_last", 32'(out_last), 32'(p_last));
      end
      if (out_valid && !p_valid) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_last", 32'(out_last), 32'(e.l));
          seen.push_back(out_data);
          rel = e.l;
        end
      end
      m_err = 0;
      if (in_valid && in_line_start) begin
        if (m_active || (m_full - int'(rel)) < 2) begin
          m_err    = m_active;
          m_active = 1;
          m_byp    = cfg_bypass;
          m_tp     = cfg_test_pattern;
          m_line[0] = m_tp ? '0 : in_data;
          m_k      = 1;
        end else begin
          set_ovf = 1;
        end
      end else if (in_valid && m_active) begin
        m_line[m_k] = m_tp ? DW'(m_k) : in_data;
        if (m_k == LL - 1) begin
          for (int j = 0; j < LL; j++) begin
            idx = m_byp ? j : (j % LPI) * IL + j / LPI;
            e.d = m_line[idx];
            e.l = (j == LL - 1);
            exp_q.push_back(e);
          end
          m_active = 0;
          m_k      = 0;
          done     = 1;
          done_cyc = cyc;
        end else begin
          m_k++;
        end
      end
      m_ovf  = set_ovf | (m_ovf & !clr_status);
      m_full = m_full - int'(rel) + int'(done);
      p_valid = out_valid;
      p_ready = out_ready;
      p_data  = out_data;
      p_last  = out_last;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid      = 1'b0;
      in_line_start = 1'b0;
    end
  endtask

  task automatic stray(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid      = 1'b1;
      in_line_start = 1'b0;
      in_data       = DW'($urandom);
    end
  endtask

  task automatic send_line(input int n, input bit byp,
                           input bit tp, input int flip_at);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid      = 1'b1;
      in_line_start = (i == 0);
      in_data       = DW'($urandom);
      if (i == 0) begin
        cfg_bypass       = byp;
        cfg_test_pattern = tp;
      end else if (i == flip_at) begin
        cfg_bypass = !byp;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_full != 0 || out_valid)
           && t < 20000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 0);
    chk("drain_full", 32'(full_banks), 0);
  endtask

  initial begin
    int e0;
    int t;
    rst_n            = 1'b0;
    in_valid         = 1'b0;
    in_data          = '0;
    in_line_start    = 1'b0;
    cfg_bypass       = 1'b0;
    cfg_test_pattern = 1'b0;
    clr_status       = 1'b0;
    ready_mode       = 1;
    cyc = 0;
    n_err = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_full_banks", 32'(full_banks), 0);
    chk("rst_wr_active", 32'(wr_active), 0);
    chk("rst_err_short", 32'(err_short), 0);
    chk("rst_ovf", 32'(ovf_sticky), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reorder + test pattern
    seen.delete();
    send_line(LL, 0, 1, -1);
    idle(1);
    drain();
    chk("t1_count", 32'(seen.size()), LL);
    chk("t1_latency", 32'(rise_cyc - done_cyc), 2);
    if (seen.size() == LL) begin
      chk("t1_beat1", 32'(seen[1]), 4);
      chk("t1_beat63", 32'(seen[63]), 252);
      chk("t1_beat64", 32'(seen[64]), 1);
      chk("t1_beat255", 32'(seen[255]), 255);
    end

    // bypass + test pattern, bypass flipped mid-line
    seen.delete();
    send_line(LL, 1, 1, 128);
    idle(1);
    drain();
    chk("t2_count", 32'(seen.size()), LL);
    if (seen.size() == LL) begin
      chk("t2_beat1", 32'(seen[1]), 1);
      chk("t2_beat200", 32'(seen[200]), 200);
    end

    // three lines with the output stalled
    seen.delete();
    ready_mode = 0;
    repeat (3) send_line(LL, 0, 0, -1);
    idle(5);
    @(negedge clk);
    chk("t3_full2", 32'(full_banks), 2);
    chk("t3_ovf", 32'(ovf_sticky), 1);
    @(posedge clk);
    #1 clr_status = 1'b1;
    @(posedge clk);
    #1 clr_status = 1'b0;
    @(negedge clk);
    chk("t3_ovf_clr", 32'(ovf_sticky), 0);
    ready_mode = 1;
    drain();
    chk("t3_count", 32'(seen.size()), 2 * LL);

    // random throttling, random config and gaps
    ready_mode = 2;
    for (int n = 0; n < 4; n++) begin
      send_line(LL, 1'($urandom), 1'($urandom), -1);
      idle($urandom_range(1, 600));
    end
    ready_mode = 1;
    drain();

    // stray samples, then a short line restarted at k=100
    seen.delete();
    stray(5);
    idle(2);
    e0 = n_err;
    send_line(100, 0, 1, -1);
    send_line(LL, 0, 1, -1);
    idle(3);
    drain();
    chk("t5_err_pulses", 32'(n_err - e0), 1);
    chk("t5_count", 32'(seen.size()), LL);

    // reset during readout
    seen.delete();
    send_line(LL, 0, 0, -1);
    idle(1);
    t = 0;
    while (seen.size() < 50 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("t6_reached50", 32'(seen.size() >= 50), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_full", 32'(full_banks), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen.delete();
    send_line(LL, 1, 0, -1);
    idle(1);
    drain();
    chk("t6_count", 32'(seen.size()), LL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
